// File: rtl/check_snapshot_streamer.sv
// ---------------------------------------------------------------------------
// check_snapshot_streamer
//
// Purpose:
//   Debug-side consumer of the segment-select debug mux. On a snapshot request
//   it steps the mux address through every segment and captures one check word
//   per cycle into a local buffer. It then streams the buffered words out over
//   a valid/ready handshake. The words leave as one coherent, time-aligned
//   snapshot, even if the live pipeline changes while they are being streamed.
//
// Ports:
//   clk        in   system clock, rising-edge active
//   rstn       in   synchronous active-low reset
//   snap_req   in   one-cycle snapshot request, accepted only in IDLE
//   check_addr out  segment address driven to the debug mux
//   check_data in   check word returned combinationally by the mux
//   busy       out  high while scanning or streaming
//   out_valid  out  stream word valid
//   out_ready  in   downstream accepts a word when out_valid & out_ready
//   out_idx    out  segment index of out_data
//   out_data   out  captured check word for out_idx
//   done       out  one-cycle pulse after the last word is accepted
//   overrun    out  sticky: snap_req seen while busy
//   dbg_state  out  current FSM state (0=IDLE, 1=SCAN, 2=STREAM)
//
// Handshake: a word transfers on a rising edge where out_valid & out_ready are
// both high. Once out_valid rises it stays high, with out_idx and out_data held
// stable, until the word transfers. out_valid never depends combinationally on
// out_ready.
// ---------------------------------------------------------------------------
module check_snapshot_streamer #(
  parameter int NUM_SEG = 6,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              snap_req,
  output logic [ADDR_W-1:0] check_addr,
  input  logic [DATA_W-1:0] check_data,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              done,
  output logic              overrun,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    STREAM = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_SEG - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] scan_cnt_q;
  logic [ADDR_W-1:0] idx_q;
  logic              out_valid_q;
  logic              done_q;
  logic              overrun_q;
  logic [DATA_W-1:0] buf_q [NUM_SEG];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < NUM_SEG; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (snap_req) begin
            state_q    <= SCAN;
            scan_cnt_q <= '0;
            overrun_q  <= 1'b0;
          end
        end
        SCAN: begin
          // The mux is combinational, so the word for the current address is
          // already present on check_data in this cycle.
          buf_q[scan_cnt_q] <= check_data;
          if (snap_req) overrun_q <= 1'b1;
          if (scan_cnt_q == LAST) begin
            state_q     <= STREAM;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b1;
          end else begin
            scan_cnt_q <= scan_cnt_q + ADDR_W'(1);
          end
        end
        STREAM: begin
          // A request on the final transfer edge still sees STREAM, so it is
          // counted as an overrun rather than accepted.
          if (snap_req) overrun_q <= 1'b1;
          if (out_valid_q && out_ready) begin
            if (idx_q == LAST) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
              idx_q       <= '0;
            end else begin
              idx_q <= idx_q + ADDR_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // scan_cnt_q is held at 0 outside SCAN, so the mux address rests at 0.
  assign check_addr = scan_cnt_q;
  assign busy       = (state_q != IDLE);
  assign out_valid  = out_valid_q;
  assign out_idx    = idx_q;
  assign out_data   = buf_q[idx_q];
  assign done       = done_q;
  assign overrun    = overrun_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_check_snapshot_streamer.sv
module tb_check_snapshot_streamer;

  localparam int NUM_SEG = 6;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 32;

  logic              clk;
  logic              rstn;
  logic              snap_req;
  logic [ADDR_W-1:0] check_addr;
  logic [DATA_W-1:0] check_data;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_idx;
  logic [DATA_W-1:0] out_data;
  logic              done;
  logic              overrun;
  logic [1:0]        dbg_state;

  logic [DATA_W-1:0] mux_base;

  int checks;
  int failures;

  check_snapshot_streamer #(
    .NUM_SEG(NUM_SEG),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .snap_req  (snap_req),
    .check_addr(check_addr),
    .check_data(check_data),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .done      (done),
    .overrun   (overrun),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // combinational debug mux model
  always_comb check_data = mux_base + DATA_W'(check_addr);

  // Inputs are changed and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // Pulse snap_req for one rising edge; returns at the negedge after that edge.
  task automatic pulse_req();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
  endtask

  task automatic test_reset();
    rstn      = 1'b0;
    snap_req  = 1'b0;
    out_ready = 1'b0;
    mux_base  = 32'h1000_0000;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    checks++;
    if ({check_addr, busy, out_valid, out_idx, out_data, done, overrun} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: addr=%0d busy=%b valid=%b idx=%0d data=%h done=%b ovr=%b, required all 0",
               check_addr, busy, out_valid, out_idx, out_data, done, overrun);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || check_addr !== '0) begin
      failures++;
      $display("FAIL idle_hold: busy=%b addr=%0d, required busy=0 addr=0", busy, check_addr);
    end
  endtask

  task automatic test_basic();
    mux_base  = 32'h1000_0000;
    out_ready = 1'b1;
    pulse_req();
    for (int i = 0; i < NUM_SEG; i++) begin
      checks++;
      if (check_addr !== ADDR_W'(i) || busy !== 1'b1 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL scan_addr[%0d]: addr=%0d busy=%b valid=%b, required addr=%0d busy=1 valid=0",
                 i, check_addr, busy, out_valid, i);
      end
      tick();
    end
    for (int i = 0; i < NUM_SEG; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== ADDR_W'(i) ||
          out_data !== 32'h1000_0000 + i || done !== 1'b0 || check_addr !== '0) begin
        failures++;
        $display("FAIL stream_word[%0d]: valid=%b idx=%0d data=%h done=%b addr=%0d, required valid=1 idx=%0d data=%h done=0 addr=0",
                 i, out_valid, out_idx, out_data, done, check_addr, i, 32'h1000_0000 + i);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse: done=%b busy=%b valid=%b, required 1 0 0", done, busy, out_valid);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL done_single: done=%b busy=%b ovr=%b, required 0 0 0", done, busy, overrun);
    end
  endtask

  task automatic test_backpressure_coherency();
    mux_base  = 32'h1000_0000;
    out_ready = 1'b1;
    pulse_req();
    for (int i = 0; i < NUM_SEG; i++) tick();
    // SCAN is over: the live pipeline now shows different words.
    mux_base = 32'hDEAD_0000;
    tick();  // idx0 -> idx1
    tick();  // idx1 -> idx2
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== 3'd2 || out_data !== 32'h1000_0002) begin
        failures++;
        $display("FAIL stall[%0d]: valid=%b idx=%0d data=%h, required 1 2 10000002",
                 k, out_valid, out_idx, out_data);
      end
      if (k < 3) tick();
    end
    out_ready = 1'b1;
    for (int i = 3; i < NUM_SEG; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_idx !== ADDR_W'(i) || out_data !== 32'h1000_0000 + i) begin
        failures++;
        $display("FAIL resume[%0d]: valid=%b idx=%0d data=%h, required valid=1 idx=%0d data=%h",
                 i, out_valid, out_idx, out_data, i, 32'h1000_0000 + i);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_done: done=%b valid=%b, required 1 0", done, out_valid);
    end
    tick();
  endtask

  task automatic test_overrun();
    mux_base  = 32'h2000_0000;
    out_ready = 1'b1;
    pulse_req();
    tick();
    tick();            // check_addr now 2
    pulse_req();       // ignored request during SCAN
    checks++;
    if (overrun !== 1'b1 || check_addr !== 3'd3 || busy !== 1'b1) begin
      failures++;
      $display("FAIL ovr_scan: ovr=%b addr=%0d busy=%b, required 1 3 1", overrun, check_addr, busy);
    end
    tick();
    tick();
    tick();            // stream idx0 visible
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd0 || out_data !== 32'h2000_0000) begin
      failures++;
      $display("FAIL ovr_stream_start: valid=%b idx=%0d data=%h, required 1 0 20000000",
               out_valid, out_idx, out_data);
    end
    pulse_req();       // ignored request during STREAM, idx0 -> idx1
    for (int i = 1; i < NUM_SEG; i++) begin
      checks++;
      if (out_idx !== ADDR_W'(i) || out_data !== 32'h2000_0000 + i || check_addr !== '0) begin
        failures++;
        $display("FAIL ovr_stream[%0d]: idx=%0d data=%h addr=%0d, required idx=%0d data=%h addr=0",
                 i, out_idx, out_data, check_addr, i, 32'h2000_0000 + i);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_done: done=%b ovr=%b, required 1 1", done, overrun);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || dbg_state !== 2'd0 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL ovr_no_rescan: busy=%b state=%0d ovr=%b, required 0 0 1", busy, dbg_state, overrun);
    end
    pulse_req();       // accepted in IDLE
    checks++;
    if (overrun !== 1'b0 || busy !== 1'b1 || dbg_state !== 2'd1) begin
      failures++;
      $display("FAIL ovr_clear: ovr=%b busy=%b state=%0d, required 0 1 1", overrun, busy, dbg_state);
    end
    // drain that snapshot: 6 scan cycles + 6 stream cycles + done cycle
    for (int i = 0; i < 2 * NUM_SEG + 1; i++) tick();
  endtask

  task automatic test_finish_collision();
    mux_base  = 32'h3000_0000;
    out_ready = 1'b1;
    pulse_req();
    for (int i = 0; i < 2 * NUM_SEG - 1; i++) tick();
    checks++;
    if (out_idx !== 3'd5 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL coll_setup: idx=%0d ovr=%b, required 5 0", out_idx, overrun);
    end
    pulse_req();       // same edge as the final transfer
    checks++;
    if (done !== 1'b1 || overrun !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL coll_end: done=%b ovr=%b busy=%b, required 1 1 0", done, overrun, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || check_addr !== '0) begin
      failures++;
      $display("FAIL coll_not_accepted: busy=%b addr=%0d, required 0 0", busy, check_addr);
    end
  endtask

  task automatic test_mid_reset();
    int done_seen;
    mux_base  = 32'h4000_0000;
    out_ready = 1'b1;
    pulse_req();
    for (int i = 0; i < NUM_SEG + 3; i++) tick();
    checks++;
    if (out_idx !== 3'd3 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_setup: idx=%0d valid=%b, required 3 1", out_idx, out_valid);
    end
    rstn = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || check_addr !== '0 || out_idx !== '0 ||
        out_data !== '0 || overrun !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: valid=%b busy=%b addr=%0d idx=%0d data=%h ovr=%b done=%b, required all 0",
               out_valid, busy, check_addr, out_idx, out_data, overrun, done);
    end
    rstn = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1 || busy !== 1'b0) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      failures++;
      $display("FAIL mid_quiet: %0d cycles with done or busy after reset, required 0", done_seen);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_backpressure_coherency();
    test_overrun();
    test_finish_collision();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/check_snapshot_streamer.md
Name: check_snapshot_streamer

Overview:
- Debug-side consumer of the segment-select debug mux.
- Drives the mux's 3-bit segment address and captures the selected 32-bit pipeline-stage check word for each segment (IF, ID, EX, MEM, WB, HZD) into a local snapshot buffer in consecutive cycles.
- Then streams the buffer word by word over a valid/ready handshake to the PDU / debug output logic.
- Gives a coherent, time-aligned snapshot of all stages without the PDU stepping the address itself.

Parameters:
- NUM_SEG, 6, number of segments scanned (addresses 0..NUM_SEG-1); legal range 1..2^ADDR_W.
- ADDR_W, 3, width of the segment address / index.
- DATA_W, 32, width of one check word.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rstn  input  1  synchronous active-low reset, sampled on rising edge of clk.
- snap_req  input  1  one-cycle snapshot request; accepted only in IDLE.
- check_addr  output  ADDR_W  segment address driven to the debug mux.
- check_data  input  DATA_W  selected check word returned combinationally by the mux for the current check_addr.
- busy  output  1  high in SCAN and STREAM.
- out_valid  output  1  stream word valid.
- out_ready  input  1  downstream accepts word when out_valid & out_ready.
- out_idx  output  ADDR_W  segment index of out_data.
- out_data  output  DATA_W  captured check word for out_idx.
- done  output  1  one-cycle pulse after the last word is accepted.
- overrun  output  1  sticky flag: snap_req seen while busy.

Behaviour:
- Reset (rstn=0 at a clock edge, any state, including mid-scan or mid-stream):
  - State goes to IDLE.
  - check_addr=0, out_idx=0, out_data=0, busy=0, out_valid=0, done=0, overrun=0.
  - All buffer entries cleared to 0.
  - No partial snapshot survives reset.
- FSM states: IDLE, SCAN, STREAM.
- IDLE:
  - check_addr=0, busy=0, out_valid=0.
  - snap_req=1 at edge T: go to SCAN and clear overrun.
- SCAN:
  - Internal counter scan_cnt starts at 0; check_addr=scan_cnt.
  - Each cycle, buf[scan_cnt] <= check_data (mux is combinational, so zero-latency capture), then scan_cnt increments.
  - When scan_cnt==NUM_SEG-1 at the edge: capture the last word, go to STREAM, idx=0.
  - SCAN occupies exactly NUM_SEG cycles; with snap_req accepted at edge T, words for addr 0..5 are captured at edges T+1..T+6.
  - check_addr returns to 0 when leaving SCAN.
- STREAM:
  - out_valid=1, out_idx=idx, out_data=buf[idx], driven from registers (no combinational path from out_ready).
  - out_valid first high in the cycle after edge T+NUM_SEG.
  - On an edge with out_valid & out_ready:
    - If idx<NUM_SEG-1, idx increments.
    - If idx==NUM_SEG-1, go to IDLE, out_valid=0, and done=1 for exactly one cycle.
  - While out_ready=0: out_data and out_idx are held stable, out_valid stays 1 (no retraction).
  - With out_ready held 1, one word is transferred per cycle.
- Request handling:
  - snap_req while busy (SCAN or STREAM) is ignored, not queued, and sets overrun=1.
  - overrun is cleared only by reset or by the next accepted snap_req.
  - snap_req in the same cycle that STREAM finishes (state still STREAM) counts as an overrun and is not accepted.
  - snap_req held high continuously in IDLE starts one snapshot; the extra cycles while busy set overrun.
- Widths: idx and scan_cnt are ADDR_W bits and never exceed NUM_SEG-1; no wrap-around is reachable.
- done and out_valid are never high in the same cycle.

Test Plan:
- Reset/idle: hold rstn=0 for 2 cycles, release. Required: all outputs 0, check_addr=0, busy=0 until snap_req.
- Basic snapshot: mux model returns 32'h1000_0000+addr; pulse snap_req with out_ready=1.
  - check_addr sequence 0,1,2,3,4,5 on 6 consecutive cycles.
  - Then out_idx 0..5 with out_data 32'h1000_0000..32'h1000_0005 on 6 consecutive cycles.
  - done pulses once; busy drops with it.
- Backpressure: out_ready=0 for 3 cycles while out_idx=2. Required: out_valid=1, out_idx=2, out_data=32'h1000_0002 stable; resumes with idx 3 after ready rises.
- Coherency: change the mux model to 32'hDEAD_0000+addr after SCAN ends. Required: streamed words are still 32'h1000_000x.
- Overrun: pulse snap_req during SCAN and during STREAM.
  - Required: overrun=1, snapshot continues unaffected, no second scan.
  - Next snap_req in IDLE clears overrun and starts a new scan.
- Mid-operation reset: assert rstn=0 while out_idx=3 in STREAM. Required: next cycle out_valid=0, busy=0, check_addr=0, done never pulses.
